// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between the instruction-fetch and data requesters.
// One transaction at a time; data wins unless fetch has waited STARVE_LIMIT grants.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              fetch_wins;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        fetch_wins   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    fetch_wins = i_req && (!d_req || (starve_cnt_q == CNT_MAX));
                    owner_d    = !fetch_wins;
                    state_d    = ISSUE;
                    if (fetch_wins) begin
                        // Fetch is read-only; wdata keeps whatever the last data write left.
                        mem_we_d     = 1'b0;
                        mem_addr_d   = i_addr;
                        mem_wstrb_d  = '0;
                        starve_cnt_d = '0;
                    end else begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_wstrb;
                        if (!i_req) begin
                            starve_cnt_d = '0;
                        end else if (starve_cnt_q != CNT_MAX) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    if (!owner_q) begin
                        i_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign i_done    = (state_q == RESP) && !owner_q;
    assign d_done    = (state_q == RESP) && owner_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates the single-port unified memory between the instruction-fetch requester (IF stage, read-only) and the data requester (MEM stage, read/write). It sequences one memory transaction at a time through a request/grant/response handshake and returns a one-cycle done pulse with read data to the winning requester. Data accesses win by default, and a starvation limit guarantees forward progress for fetch.

## Interface
- ADDR_W, 32, address width of both requesters and memory side
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (≥1)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- i_req  in  1  fetch request; held with i_addr stable until i_done
- i_addr  in  ADDR_W  fetch address
- i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_W  fetched word; held until next fetch completes
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wstrb stable until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wstrb  in  DATA_W/8  write byte enables
- d_done  out  1  one-cycle pulse: data access complete, d_rdata valid for reads
- d_rdata  out  DATA_W  read data; held until next data read completes
- mem_req  out  1  memory request, held until mem_gnt
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response (read data or write ack) this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid
- busy  out  1  state ≠ IDLE
- owner  out  1  0 = fetch, 1 = data; valid while busy

## Operation
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE: if neither req, stay. Otherwise arbitrate, latch owner and request fields into mem_* registers, go to ISSUE.
  - Arbitration: data wins unless i_req=1 and starve_cnt=STARVE_LIMIT, in which case fetch wins.
- starve_cnt (clog2(STARVE_LIMIT+1) bits), updated only at arbitration:
  - +1 on a data grant while i_req=1
  - cleared on a fetch grant or on a data grant with i_req=0
  - saturates at STARVE_LIMIT
- Fetch grant drives mem_we=0 and mem_wstrb=0, with mem_wdata unchanged.
- ISSUE: mem_req=1; on mem_gnt go to WAIT. Fields stay stable while mem_gnt=0.
- WAIT: on mem_rvalid, capture mem_rdata into the owner's rdata register (reads only; the other rdata is untouched), go to RESP. A write's d_rdata is unchanged.
- RESP: assert owner's done for exactly one cycle, then IDLE. A req seen in IDLE after RESP is a new request.
- mem_rvalid outside WAIT and mem_gnt outside ISSUE are ignored.
- The arbiter supports only one outstanding transaction. No address alignment checks; addresses pass through unmodified.
- Reset (any state, including mid-ISSUE/WAIT):
  - state IDLE, starve_cnt=0
  - mem_req, mem_we, i_done, d_done, busy, owner = 0
  - mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata = 0
  - an in-flight memory transaction is abandoned; memory is reset concurrently.

## Timing
- All outputs are registered or decoded from state; no combinational path from req inputs to mem_* outputs.
- Minimum latency: req high in IDLE at cycle t → mem_req t+1 → (mem_gnt at t+1) WAIT t+2 → (mem_rvalid at t+2) done at t+3 → IDLE t+4.
- Each cycle of mem_gnt low adds one cycle; each cycle of rvalid delay adds one cycle.
- Back-to-back throughput with zero-wait memory: one transaction per 4 cycles.
- Simultaneous i_req and d_req with starve_cnt<STARVE_LIMIT: data first, fetch next (fetch's counter increments).

## Test plan
- Reset: assert reset mid-WAIT with mem_rvalid pending → all outputs 0 next cycle; a later mem_rvalid=1 in IDLE produces no done.
- Single fetch: i_req, i_addr=0x100, zero-wait memory returning 0xDEADBEEF → mem_req at t+1 with mem_we=0 and mem_wstrb=0; i_done at t+3; i_rdata=0xDEADBEEF.
- Contention: i_req and d_req (read 0x200) rise together → data served first (d_done t+3), fetch mem_req at t+5, i_done t+7.
- Starvation, STARVE_LIMIT=2: i_req held while d_req re-requests after every d_done → grant order D, D, I, D, D, I.
- Backpressure: d write 0x300, wdata=0x11223344, wstrb=0b0101, mem_gnt low 3 cycles → mem_* fields stable all 3 cycles; d_done one cycle after mem_rvalid; d_rdata unchanged.
- Spurious responses: mem_rvalid pulsed in IDLE/ISSUE and mem_gnt pulsed in WAIT → no state change, no done.
